// File: rtl/pow_rr_engine.sv
// pow_rr_engine: shared base^exp engine, right-to-left square-and-multiply,
// one exponent bit per cycle, two requesters arbitrated round-robin.
// Ports: clk, resetn (async active-low); req0/req1 valid/ready/base/exp;
//        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_ovf; busy.
// Build option: POW_SAT_EN saturates rsp_result to all ones on overflow.
module pow_rr_engine #(
    parameter int BASE_W = 4,
    parameter int EXP_W  = 4,
    parameter int RES_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [BASE_W-1:0] req0_base,
    input  logic [EXP_W-1:0]  req0_exp,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [BASE_W-1:0] req1_base,
    input  logic [EXP_W-1:0]  req1_exp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_ovf,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] STEP = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [RES_W-1:0]   acc;
    logic [RES_W-1:0]   b;
    logic [EXP_W-1:0]   e;
    logic               b_ovf;
    logic               ovf;
    logic               id;
    logic               last;
    logic               gnt;
    logic               any_req;
    logic               accept;
    logic [2*RES_W-1:0] mul_acc;
    logic [2*RES_W-1:0] mul_sq;

    // Tie goes to the requester not served last.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid)
            gnt = ~last;
        else
            gnt = req1_valid;
    end

    assign any_req    = req0_valid | req1_valid;
    assign req0_ready = (state == IDLE) && any_req && !gnt;
    assign req1_ready = (state == IDLE) && any_req && gnt;
    assign accept     = (state == IDLE) && any_req;

    assign mul_acc = {{RES_W{1'b0}}, acc} * {{RES_W{1'b0}}, b};
    assign mul_sq  = {{RES_W{1'b0}}, b} * {{RES_W{1'b0}}, b};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            acc   <= '0;
            b     <= '0;
            e     <= '0;
            b_ovf <= 1'b0;
            ovf   <= 1'b0;
            id    <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= RES_W'(1);
                        b     <= gnt ? RES_W'(req1_base) : RES_W'(req0_base);
                        e     <= gnt ? req1_exp : req0_exp;
                        b_ovf <= 1'b0;
                        ovf   <= 1'b0;
                        id    <= gnt;
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (e != '0) begin
                        // A squared-base overflow only matters once it is
                        // actually folded into the accumulator.
                        if (e[0]) begin
                            acc <= mul_acc[RES_W-1:0];
                            ovf <= ovf | b_ovf
                                 | (mul_acc[2*RES_W-1:RES_W] != '0);
                        end
                        b     <= mul_sq[RES_W-1:0];
                        b_ovf <= b_ovf | (mul_sq[2*RES_W-1:RES_W] != '0);
                        e     <= e >> 1;
                    end else begin
                        last  <= id;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = id;
    assign rsp_ovf   = ovf;
    assign busy      = (state != IDLE);

`ifdef POW_SAT_EN
    assign rsp_result = ovf ? {RES_W{1'b1}} : acc;
`else
    assign rsp_result = acc;
`endif

endmodule
